mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter MAX_DATA_STREAK, default 4, giving the maximum consecutive data grants while fetch is waiting (range 1..7).
REQ-002 SHALL provide port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL provide port if_req, input, 1 bit: instruction-fetch request, held high until if_ack.
REQ-005 SHALL provide port if_addr, input, 32 bits: fetch address, stable while if_req is high.
REQ-006 SHALL provide port if_rdata, output, 32 bits: fetched instruction, valid when if_ack is high.
REQ-007 SHALL provide port if_ack, output, 1 bit: one-cycle fetch completion pulse.
REQ-008 SHALL provide port d_req, input, 1 bit: load/store request, held high until d_ack.
REQ-009 SHALL provide port d_we, input, 1 bit: 0 = load, 1 = store.
REQ-010 SHALL provide ports d_addr, d_wdata (input, 32 bits) and d_funct3 (input, 3 bits): access address, store data and size/sign code.
REQ-011 SHALL provide port d_rdata, output, 32 bits: load data, valid when d_ack is high.
REQ-012 SHALL provide port d_ack, output, 1 bit: one-cycle data completion pulse.
REQ-013 SHALL provide ports mem_req, mem_we (output, 1 bit), mem_addr, mem_wdata (output, 32 bits) and mem_funct3 (output, 3 bits): the shared-memory command, all registered.
REQ-014 SHALL provide ports mem_rdata (input, 32 bits) and mem_ready (input, 1 bit): memory read data and completion, sampled only while mem_req is high.
REQ-015 SHALL provide port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 SHALL implement four states: IDLE, ISSUE_IF, ISSUE_D and RESP.
REQ-017 IDLE with d_req=1 and no fairness override SHALL register d_* onto mem_*, set mem_req=1 and go to ISSUE_D.
REQ-018 IDLE with only if_req=1, or with a fairness override, SHALL register if_addr onto mem_addr with mem_we=0 and mem_funct3=3'b010, set mem_req=1 and go to ISSUE_IF.
REQ-019 IDLE with no request SHALL remain in IDLE with mem_req=0.
REQ-020 ISSUE_x SHALL hold all mem_* outputs constant until mem_ready=1; at that edge it SHALL capture mem_rdata into the owner's rdata register, drive mem_req=0 and go to RESP.
REQ-021 RESP SHALL pulse the owner's ack for exactly one cycle and then return to IDLE; the ack SHALL NOT reach the non-owner.
REQ-022 Requesters SHALL drop req at the edge that samples ack, so IDLE never re-grants a completed request.
REQ-023 Minimum latency SHALL be req rising in cycle N, mem_req high in N+1, and with mem_ready=1 in N+1, ack high in N+2.
REQ-024 if_rdata and d_rdata SHALL hold their last captured value until the next capture for that owner; a store SHALL also capture mem_rdata.
REQ-025 No more than one transaction SHALL be outstanding, and if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-026 reset=1 SHALL force IDLE and mem_req=0, mem_we=0, if_ack=0, d_ack=0, busy=0, the streak counter to 0, and all data/address outputs to 0.
REQ-027 reset during ISSUE_x or RESP SHALL abandon the transaction without any ack; mem_req SHALL be 0 in the cycle after the reset edge.
REQ-028 reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-029 With ARB_FAIRNESS_EN defined, a 3-bit streak counter SHALL increment on each data grant made while if_req=1 and clear on each fetch grant.
REQ-030 With ARB_FAIRNESS_EN defined, a fairness override SHALL occur when the counter equals MAX_DATA_STREAK and both requests are high.
REQ-031 With ARB_FAIRNESS_EN undefined, data SHALL have strict priority and the streak counter SHALL NOT exist.

Verification
REQ-032 Scenario 1: if_req=1, if_addr=0x10, mem_ready=1 with mem_rdata=0x00500093 -> mem_req in cycle 1 and if_ack=1 with if_rdata=0x00500093 in cycle 2.
REQ-033 Scenario 2: if_req and d_req rise in the same cycle, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> store issued first with mem_we=1, then the fetch issues after d_ack.
REQ-034 Scenario 3: mem_ready held 0 for 5 cycles in ISSUE_D -> mem_addr/mem_wdata stable throughout, d_ack only in the cycle after mem_ready=1.
REQ-035 Scenario 4: with ARB_FAIRNESS_EN and MAX_DATA_STREAK=4, d_req and if_req held continuously -> grant order D,D,D,D,IF,D,D,D,D,IF; without the macro, IF is never granted.
REQ-036 Scenario 5: reset asserted in ISSUE_IF -> no if_ack, mem_req=0 the next cycle, busy=0, and a fresh request afterwards completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and load/store.
// Define ARB_FAIRNESS_EN to bound consecutive data grants while a fetch waits.
module mem_arbiter #(
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_funct3,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_funct3,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE_IF,
      ISSUE_D,
      RESP
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_owner_d;
   logic   w_fair;
   logic   w_grant_d;
   logic   w_grant_if;

`ifdef ARB_FAIRNESS_EN
   logic [2:0] r_streak;

   assign w_fair = if_req && d_req &&
                   (r_streak == 3'(MAX_DATA_STREAK));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_streak <= '0;
      end else if (r_state == IDLE) begin
         if (w_grant_if)
            r_streak <= '0;
         else if (w_grant_d && if_req)
            r_streak <= r_streak + 3'd1;
      end
   end
`else
   logic w_unused_streak;

   assign w_fair          = 1'b0;
   assign w_unused_streak = (MAX_DATA_STREAK == 0);
`endif

   // Data wins unless the streak limit hands this slot to fetch.
   assign w_grant_d  = d_req && !w_fair;
   assign w_grant_if = if_req && !w_grant_d;

   always_ff @(posedge clock) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_grant_d)
               w_next = ISSUE_D;
            else if (w_grant_if)
               w_next = ISSUE_IF;
         end
         ISSUE_IF,
         ISSUE_D: begin
            if (mem_ready)
               w_next = RESP;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_owner_d  <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_funct3 <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  r_owner_d  <= 1'b1;
                  mem_req    <= 1'b1;
                  mem_we     <= d_we;
                  mem_addr   <= d_addr;
                  mem_wdata  <= d_wdata;
                  mem_funct3 <= d_funct3;
               end else if (w_grant_if) begin
                  r_owner_d  <= 1'b0;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  mem_funct3 <= 3'b010;
               end
            end
            ISSUE_IF,
            ISSUE_D: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  if (r_state == ISSUE_D)
                     d_rdata <= mem_rdata;
                  else
                     if_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign if_ack = (r_state == RESP) && !r_owner_d;
   assign d_ack  = (r_state == RESP) && r_owner_d;
   assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-controlled
// memory model and self-reissuing requesters.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [2:0]  d_funct3;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        busy;

   mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata),
      .if_ack     (if_ack),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_funct3   (d_funct3),
      .d_rdata    (d_rdata),
      .d_ack      (d_ack),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_funct3 (mem_funct3),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q_if[$];
   logic [31:0] q_d[$];
   logic [7:0]  grants[$];
   int          cyc = 0;
   int          lat = 0;
   int          wait_cnt = 0;
   int          ready_cyc = -10;
   bit          cmd_open = 0;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   int          if_reissue = 0;
   int          d_reissue = 0;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      if (a == 32'h10)
         return 32'h0050_0093;
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      mem_ready = 1'b0;
      if (if_ack || d_ack)
         check("ack_excl", 32'(if_ack & d_ack), 32'd0);
      if (if_ack) begin
         check("if_pending", 32'(q_if.size()), 32'd1);
         if (q_if.size() > 0)
            check("if_rdata", if_rdata, q_if.pop_front());
         check("if_ack_lat", 32'(cyc), 32'(ready_cyc + 1));
         if (if_reissue > 0) begin
            if_reissue--;
            if_addr = if_addr + 32'd4;
            q_if.push_back(mem_f(if_addr));
         end else begin
            if_req = 1'b0;
         end
      end
      if (d_ack) begin
         check("d_pending", 32'(q_d.size()), 32'd1);
         if (q_d.size() > 0)
            check("d_rdata", d_rdata, q_d.pop_front());
         check("d_ack_lat", 32'(cyc), 32'(ready_cyc + 1));
         if (d_reissue > 0) begin
            d_reissue--;
            d_addr = d_addr + 32'd4;
            q_d.push_back(mem_f(d_addr));
         end else begin
            d_req = 1'b0;
         end
      end
      if (mem_req) begin
         if (!cmd_open) begin
            cmd_open  = 1;
            wait_cnt  = 0;
            cmd_addr  = mem_addr;
            cmd_wdata = mem_wdata;
            grants.push_back((mem_addr >= 32'h100) ? 8'h44 : 8'h49);
         end else begin
            check("mem_addr_hold", mem_addr, cmd_addr);
            check("mem_wdata_hold", mem_wdata, cmd_wdata);
         end
         if (wait_cnt >= lat) begin
            mem_ready = 1'b1;
            mem_rdata = mem_f(mem_addr);
            ready_cyc = cyc;
            cmd_open  = 0;
         end else begin
            wait_cnt++;
            mem_rdata = $urandom;
         end
      end else begin
         cmd_open = 0;
      end
   endtask

   task automatic fetch(input logic [31:0] a);
      if_addr = a;
      if_req  = 1'b1;
      q_if.push_back(mem_f(a));
   endtask

   task automatic data(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
      d_we     = we;
      d_addr   = a;
      d_wdata  = wd;
      d_funct3 = f3;
      d_req    = 1'b1;
      q_d.push_back(mem_f(a));
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((if_req || d_req || busy) && n < maxc) begin
         tick();
         n++;
      end
      check("drain_done", 32'(if_req | d_req | busy), 32'd0);
   endtask

   initial begin
      string exp_order;
      int    n;
      reset     = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      d_funct3  = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      tick();
      tick();
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_if_ack", 32'(if_ack), 32'd0);
      check("rst_d_ack", 32'(d_ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      reset = 1'b0;
      tick();

      // Minimum-latency fetch
      lat = 0;
      fetch(32'h10);
      tick();
      check("s1_mem_req", 32'(mem_req), 32'd1);
      check("s1_mem_addr", mem_addr, 32'h10);
      check("s1_mem_funct3", 32'(mem_funct3), 32'd2);
      check("s1_mem_we", 32'(mem_we), 32'd0);
      tick();
      check("s1_if_ack", 32'(if_ack), 32'd1);
      check("s1_if_rdata", if_rdata, 32'h0050_0093);
      tick();
      check("s1_ack_pulse", 32'(if_ack), 32'd0);
      check("s1_idle", 32'(busy), 32'd0);

      // Simultaneous store and fetch: store first
      grants.delete();
      fetch(32'h14);
      data(1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010);
      tick();
      check("s2_mem_we", 32'(mem_we), 32'd1);
      check("s2_mem_addr", mem_addr, 32'h100);
      check("s2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      drain(50);
      check("s2_grants", 32'(grants.size()), 32'd2);
      if (grants.size() == 2) begin
         check("s2_first", 32'(grants[0]), 32'h44);
         check("s2_second", 32'(grants[1]), 32'h49);
      end

      // Slow memory on a load
      lat = 5;
      data(1'b0, 32'h300, 32'h1234_5678, 3'b100);
      tick();
      check("s3_mem_funct3", 32'(mem_funct3), 32'd4);
      check("s3_mem_we", 32'(mem_we), 32'd0);
      drain(50);
      lat = 0;
      tick();
      tick();
      check("s3_d_hold", d_rdata, mem_f(32'h300));
      check("s3_if_hold", if_rdata, mem_f(32'h14));

      // Reset while a fetch is outstanding
      lat = 20;
      fetch(32'h40);
      n = 0;
      while (!mem_req && n < 10) begin
         tick();
         n++;
      end
      check("s5_issued", 32'(mem_req), 32'd1);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if_req = 1'b0;
      q_if.delete();
      check("s5_mem_req", 32'(mem_req), 32'd0);
      check("s5_busy", 32'(busy), 32'd0);
      check("s5_if_ack", 32'(if_ack), 32'd0);
      check("s5_mem_addr", mem_addr, 32'd0);
      check("s5_if_rdata", if_rdata, 32'd0);
      tick();
      tick();
      check("s5_still_idle", 32'(busy), 32'd0);
      lat = 0;
      fetch(32'h44);
      drain(50);
      check("s5_fresh", if_rdata, mem_f(32'h44));

      // Both requesters held continuously
      grants.delete();
      if_reissue = 100;
      d_reissue  = 100;
      fetch(32'h20);
      data(1'b0, 32'h200, 32'h0, 3'b010);
      n = 0;
      while (grants.size() < 10 && n < 300) begin
         tick();
         n++;
      end
      if_reissue = 0;
      d_reissue  = 0;
      drain(100);
      check("s4_grants", 32'(grants.size() >= 10), 32'd1);
`ifdef ARB_FAIRNESS_EN
      exp_order = "DDDDIDDDDI";
`else
      exp_order = "DDDDDDDDDD";
`endif
      for (int i = 0; i < 10; i++) begin
         if (i < grants.size())
            check($sformatf("s4_grant%0d", i), 32'(grants[i]),
                  32'(exp_order[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
